// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 icode/ifun/condition-code constants
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_CMOVXX = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam int CF_OF = 0;
    localparam int CF_ZF = 1;
    localparam int CF_SF = 2;

    localparam logic [2:0] CC_RESET = 3'b010;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SQUASH = 1'b1
    } br_state_t;

endpackage

// File: rtl/y86_cc_branch_ctrl_if.sv
// rtl/y86_cc_branch_ctrl_if.sv - E-stage to CC/branch controller signal bundle
interface y86_cc_branch_ctrl_if #(
    parameter int ADDR_W = 64
);
    logic              e_valid;
    logic [3:0]        e_icode;
    logic [3:0]        e_ifun;
    logic [2:0]        alu_cf;
    logic [ADDR_W-1:0] e_valp;
    logic              stall_e;
    logic              m_exc;
    logic              w_exc;
    logic [2:0]        cc;
    logic              e_cnd;
    logic              cmov_suppress;
    logic              bad_ifun;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              squash_d;
    logic              squash_e;
    logic              cc_frozen;

    modport master (
        output e_valid, e_icode, e_ifun, alu_cf, e_valp, stall_e, m_exc, w_exc,
        input  cc, e_cnd, cmov_suppress, bad_ifun, redirect_valid, redirect_pc,
               squash_d, squash_e, cc_frozen
    );

    modport slave (
        input  e_valid, e_icode, e_ifun, alu_cf, e_valp, stall_e, m_exc, w_exc,
        output cc, e_cnd, cmov_suppress, bad_ifun, redirect_valid, redirect_pc,
               squash_d, squash_e, cc_frozen
    );
endinterface

// File: rtl/y86_cond_eval.sv
// rtl/y86_cond_eval.sv - jXX/cmovXX condition decode against the CC register
module y86_cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic [2:0] cc,
    output logic       cnd,
    output logic       bad
);

    logic lt;
    logic zf;

    assign lt = cc[CF_SF] ^ cc[CF_OF];
    assign zf = cc[CF_ZF];

    always_comb begin
        cnd = 1'b0;
        bad = 1'b0;
        case (ifun)
            C_ALWAYS: cnd = 1'b1;
            C_LE:     cnd = lt | zf;
            C_L:      cnd = lt;
            C_E:      cnd = zf;
            C_NE:     cnd = ~zf;
            C_GE:     cnd = ~lt;
            C_G:      cnd = ~lt & ~zf;
            default:  bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/y86_cc_branch_ctrl.sv
// rtl/y86_cc_branch_ctrl.sv - CC register, condition resolve and mispredict squash sequencer
module y86_cc_branch_ctrl
    import y86_pkg::*;
#(
    parameter int ADDR_W        = 64,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    y86_cc_branch_ctrl_if.slave  bus
);

    localparam logic [2:0] SQ_LOAD = 3'(SQUASH_CYCLES);

    br_state_t         state_q;
    br_state_t         state_d;
    logic [2:0]        sq_cnt_q;
    logic [2:0]        cc_q;
    logic              frozen_q;
    logic              redir_q;
    logic [ADDR_W-1:0] pc_q;

    logic cnd;
    logic bad;
    logic is_idle;
    logic is_br;
    logic live;
    logic cc_we;
    logic mispredict;

    y86_cond_eval u_cond (
        .ifun (bus.e_ifun),
        .cc   (cc_q),
        .cnd  (cnd),
        .bad  (bad)
    );

    assign is_idle = (state_q == ST_IDLE);
    assign is_br   = bus.e_valid & is_idle &
                     ((bus.e_icode == ICODE_JXX) | (bus.e_icode == ICODE_CMOVXX));
    // An exception in M/W this cycle already blocks E, so freeze wins over a same-cycle OPq
    assign live    = bus.e_valid & is_idle & ~frozen_q & ~bus.m_exc & ~bus.w_exc;
    assign cc_we   = live & (bus.e_icode == ICODE_OPQ) & ~bus.stall_e;
    assign mispredict = live & (bus.e_icode == ICODE_JXX) & (bus.e_ifun != C_ALWAYS) &
                        ~cnd & ~bus.stall_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (mispredict) state_d = ST_SQUASH;
            ST_SQUASH: if (sq_cnt_q == 3'd1) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q     <= CC_RESET;
            frozen_q <= 1'b0;
            sq_cnt_q <= 3'd0;
            redir_q  <= 1'b0;
            pc_q     <= '0;
        end else begin
            if (bus.m_exc || bus.w_exc) begin
                frozen_q <= 1'b1;
            end
            if (cc_we) begin
                cc_q <= bus.alu_cf;
            end
            redir_q <= mispredict;
            if (mispredict) begin
                pc_q     <= bus.e_valp;
                sq_cnt_q <= SQ_LOAD;
            end else if (sq_cnt_q != 3'd0) begin
                sq_cnt_q <= sq_cnt_q - 3'd1;
            end
        end
    end

    always_comb begin
        bus.squash_e      = (state_q == ST_SQUASH);
        bus.e_cnd         = is_br & cnd;
        bus.cmov_suppress = is_br & (bus.e_icode == ICODE_CMOVXX) & ~cnd;
        bus.bad_ifun      = is_br & bad;
    end

    assign bus.cc             = cc_q;
    assign bus.cc_frozen      = frozen_q;
    assign bus.redirect_valid = redir_q;
    assign bus.redirect_pc    = pc_q;
    assign bus.squash_d       = redir_q;

endmodule
